// File: rtl/arm_shift_seq_pkg.sv
// Shared types and constants for the operand-2 shift sequencer.
// Consumed by arm_shift_sequencer and arm_shift_operand_sel.
package arm_shift_seq_pkg;

   typedef enum logic [1:0] {IDLE, RD_RM, RD_RS, DONE} shseq_state_t;
   typedef enum {IMM, ISHIFT, RSHIFT} shseq_class_t;

   localparam logic [3:0] REG_PC = 4'd15;

   // Operand-2 form from inst[25] (immediate) and inst[4] (register-specified shift amount).
   function automatic shseq_class_t classify(input logic imm_bit, input logic reg_shift_bit);
      if (imm_bit)
         return IMM;
      else if (reg_shift_bit)
         return RSHIFT;
      else
         return ISHIFT;
   endfunction

endpackage

// File: rtl/arm_shift_operand_sel.sv
// Picks the captured operand value: PC plus pipeline offset for R15, else register-file data.
// With ARM_SHIFT_FWD_EN defined, a matching writeback bypass overrides the register file.
module arm_shift_operand_sel
   import arm_shift_seq_pkg::*;
#(
   parameter logic [31:0] PC_OFS_IMM = 32'd8,
   parameter logic [31:0] PC_OFS_REG = 32'd12
) (
   input  logic [3:0]  raddr,
   input  logic [31:0] rdata,
   input  logic [31:0] pc,
   input  logic        reg_shift,
   input  logic        fwd_we,
   input  logic [3:0]  fwd_addr,
   input  logic [31:0] fwd_data,
   output logic [31:0] operand
);

`ifdef ARM_SHIFT_FWD_EN
   always_comb begin
      // NOTE: assign a default first so no path through the block leaves operand unassigned (latch).
      operand = rdata;
      if (raddr == REG_PC)
         operand = pc + (reg_shift ? PC_OFS_REG : PC_OFS_IMM);
      else if (fwd_we && (fwd_addr == raddr))
         operand = fwd_data;
   end
`else
   always_comb begin
      operand = rdata;
      if (raddr == REG_PC)
         operand = pc + (reg_shift ? PC_OFS_REG : PC_OFS_IMM);
   end

   logic unused_fwd;
   assign unused_fwd = ^{fwd_we, fwd_addr, fwd_data};
`endif

endmodule

// File: rtl/arm_shift_sequencer.sv
// Serial Rm/Rs fetch through one register-file read port, feeding the operand-2 shifter.
// Optional writeback bypass is enabled by defining ARM_SHIFT_FWD_EN.
module arm_shift_sequencer
   import arm_shift_seq_pkg::*;
#(
   parameter logic [31:0] PC_OFS_IMM = 32'd8,
   parameter logic [31:0] PC_OFS_REG = 32'd12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic [3:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   input  logic        fwd_we,
   input  logic [3:0]  fwd_addr,
   input  logic [31:0] fwd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_inst_11_0,
   output logic [31:0] out_rm_data,
   output logic [31:0] out_rs_data,
   output logic        out_is_imm,
   output logic        stall
);

   shseq_state_t state;
   shseq_class_t cls_q;
   logic [31:0]  pc_q;
   logic [31:0]  operand;
   logic         accept;

   assign in_ready = ~rst & ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign stall    = in_valid & ~in_ready;

   logic unused_inst;
   assign unused_inst = ^{in_inst[31:26], in_inst[24:12]};

   arm_shift_operand_sel #(
      .PC_OFS_IMM (PC_OFS_IMM),
      .PC_OFS_REG (PC_OFS_REG)
   ) u_operand_sel (
      .raddr     (rf_raddr),
      .rdata     (rf_rdata),
      .pc        (pc_q),
      .reg_shift (cls_q == RSHIFT),
      .fwd_we    (fwd_we),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .operand   (operand)
   );

   // The output bundle doubles as the instruction latch; rf_raddr is registered so it is
   // already pointing at the right register on the first cycle of each read state.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state         <= IDLE;
         cls_q         <= IMM;
         pc_q          <= '0;
         rf_raddr      <= '0;
         out_valid     <= 1'b0;
         out_inst_11_0 <= '0;
         out_rm_data   <= '0;
         out_rs_data   <= '0;
         out_is_imm    <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         rf_raddr  <= '0;
      end else if (accept) begin
         pc_q          <= in_pc;
         cls_q         <= classify(in_inst[25], in_inst[4]);
         out_inst_11_0 <= in_inst[11:0];
         out_is_imm    <= in_inst[25];
         out_rm_data   <= '0;
         out_rs_data   <= '0;
         if (in_inst[25]) begin
            state     <= DONE;
            out_valid <= 1'b1;
            rf_raddr  <= '0;
         end else begin
            state     <= RD_RM;
            out_valid <= 1'b0;
            rf_raddr  <= in_inst[3:0];
         end
      end else begin
         case (state)
            RD_RM: begin
               out_rm_data <= operand;
               if (cls_q == RSHIFT) begin
                  state    <= RD_RS;
                  rf_raddr <= out_inst_11_0[11:8];
               end else begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  rf_raddr  <= '0;
               end
            end
            RD_RS: begin
               out_rs_data <= operand;
               state       <= DONE;
               out_valid   <= 1'b1;
               rf_raddr    <= '0;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_arm_shift_sequencer.sv
// Randomized bench for arm_shift_sequencer against a latency/transaction-level reference model.
// Define ARM_SHIFT_FWD_EN for both bench and RTL to exercise the writeback bypass.
module tb_arm_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] in_inst, in_pc;
   logic [3:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        fwd_we;
   logic [3:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic        out_valid, out_ready, out_is_imm, stall;
   logic [11:0] out_inst_11_0;
   logic [31:0] out_rm_data, out_rs_data;

   logic [31:0] regs [16];
   assign rf_rdata = regs[rf_raddr];

   always #5 clk = ~clk;

   arm_shift_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_inst       (in_inst),
      .in_pc         (in_pc),
      .rf_raddr      (rf_raddr),
      .rf_rdata      (rf_rdata),
      .fwd_we        (fwd_we),
      .fwd_addr      (fwd_addr),
      .fwd_data      (fwd_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst_11_0 (out_inst_11_0),
      .out_rm_data   (out_rm_data),
      .out_rs_data   (out_rs_data),
      .out_is_imm    (out_is_imm),
      .stall         (stall)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: one op in flight, described by its age in cycles since acceptance.
   // Latency is 1/2/3 cycles for immediate / immediate shift / register shift.
   bit          m_busy;
   int          m_age;
   int          m_cls;   // 0 immediate, 1 immediate shift, 2 register shift
   logic [31:0] m_inst, m_pc, m_rm, m_rs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_operand(input logic [3:0] a);
      if (a == 4'd15)
         return m_pc + ((m_cls == 2) ? 32'd12 : 32'd8);
`ifdef ARM_SHIFT_FWD_EN
      if (fwd_we && (fwd_addr == a))
         return fwd_data;
`endif
      return regs[a];
   endfunction

   task automatic model_clear();
      m_busy = 1'b0;
      m_age  = 0;
      m_cls  = 0;
      m_inst = '0;
      m_pc   = '0;
      m_rm   = '0;
      m_rs   = '0;
   endtask

   // Compare the DUT against the model for the current cycle, then advance the model
   // across the coming rising edge using the inputs that are being presented.
   task automatic eval_cycle();
      logic       exp_valid, exp_ready;
      logic [3:0] exp_raddr;
      int         lat;
      lat       = m_cls + 1;
      exp_valid = m_busy && (m_age >= lat);
      exp_ready = !rst && !flush && (!m_busy || (exp_valid && out_ready));
      exp_raddr = 4'd0;
      if (m_busy && (m_age < lat))
         exp_raddr = (m_age == 1) ? m_inst[3:0] : m_inst[11:8];

      check("in_ready",  32'(in_ready),  32'(exp_ready));
      check("stall",     32'(stall),     32'(in_valid & ~exp_ready));
      check("rf_raddr",  32'(rf_raddr),  32'(exp_raddr));
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("out_inst", 32'(out_inst_11_0), 32'(m_inst[11:0]));
         check("out_imm",  32'(out_is_imm),    32'(m_inst[25]));
         check("out_rm",   out_rm_data,        m_rm);
         check("out_rs",   out_rs_data,        m_rs);
      end

      if (rst) begin
         model_clear();
      end else if (flush) begin
         m_busy = 1'b0;
      end else if (m_busy && (m_age < lat)) begin
         if (m_age == 1) m_rm = exp_operand(exp_raddr);
         else            m_rs = exp_operand(exp_raddr);
         m_age++;
      end else if (in_valid && exp_ready) begin
         m_busy = 1'b1;
         m_age  = 1;
         m_inst = in_inst;
         m_pc   = in_pc;
         m_cls  = in_inst[25] ? 0 : (in_inst[4] ? 2 : 1);
         m_rm   = '0;
         m_rs   = '0;
      end else if (exp_valid && out_ready) begin
         m_busy = 1'b0;
      end
   endtask

   task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic r);
      @(negedge clk);
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      #1;
      eval_cycle();
   endtask

   // Accept one op while holding out_ready low, then sit until it should be presented.
   task automatic run_op(input logic [31:0] inst, input logic [31:0] pc, input int lat);
      cycle(1'b1, inst, pc, 1'b0, 1'b0, 1'b0);
      repeat (lat) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("lat_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] i;
      int          k;
      i     = $urandom;
      k     = $urandom_range(0, 2);
      i[25] = (k == 0);
      i[4]  = (k == 2);
      if ($urandom_range(0, 5) == 0) i[3:0]  = 4'hF;
      if ($urandom_range(0, 5) == 0) i[11:8] = 4'hF;
      return i;
   endfunction

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i);
      regs[2]  = 32'h11;
      regs[3]  = 32'h20;
      regs[15] = 32'hDEAD_BEEF;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
      out_ready = 1'b0; fwd_we = 1'b0; fwd_addr = '0; fwd_data = '0;
      repeat (2) @(posedge clk);
      model_clear();

      // Reset state
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("rst_ready", 32'(in_ready),      32'd1);
      check("rst_raddr", 32'(rf_raddr),      32'd0);
      check("rst_valid", 32'(out_valid),     32'd0);
      check("rst_inst",  32'(out_inst_11_0), 32'd0);
      check("rst_rm",    out_rm_data,        32'd0);
      check("rst_rs",    out_rs_data,        32'd0);
      check("rst_imm",   32'(out_is_imm),    32'd0);

      // Immediate: no register read, valid one cycle after accept
      run_op(32'hE3A01CFF, 32'h40, 1);
      check("imm_rm",   out_rm_data,        32'd0);
      check("imm_rs",   out_rs_data,        32'd0);
      check("imm_flag", 32'(out_is_imm),    32'd1);
      check("imm_inst", 32'(out_inst_11_0), 32'hCFF);
      drain();

      // Immediate shift of r2, then register shift r2 LSL r3
      run_op(32'hE1A01102, 32'h44, 2);
      check("ish_rm", out_rm_data, 32'h11);
      check("ish_rs", out_rs_data, 32'd0);
      drain();
      run_op(32'hE1A01312, 32'h48, 3);
      check("rsh_rm", out_rm_data, 32'h11);
      check("rsh_rs", out_rs_data, 32'h20);
      drain();

      // R15 as Rm: +8 for immediate shift, +12 for register shift, wrap at 2^32
      run_op(32'hE1A0100F, 32'h100, 2);
      check("pc_ish", out_rm_data, 32'h108);
      drain();
      run_op(32'hE1A0131F, 32'h100, 3);
      check("pc_rsh", out_rm_data, 32'h10C);
      drain();
      run_op(32'hE1A0100F, 32'hFFFF_FFFC, 2);
      check("pc_wrap", out_rm_data, 32'h4);
      drain();

      // Backpressure in DONE with a waiting instruction, then same-edge hand-off
      cycle(1'b1, 32'hE3A01CFF, 32'h50, 1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b1, 32'hE1A01102, 32'h54, 1'b0, 1'b0, 1'b0);
      check("bp_inst", 32'(out_inst_11_0), 32'hCFF);
      cycle(1'b1, 32'hE1A01102, 32'h54, 1'b1, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Flush during the Rs read, with a competing in_valid that must not be taken
      cycle(1'b1, 32'hE1A01312, 32'h60, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'hE3A01CFF, 32'h64, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("flush_valid", 32'(out_valid), 32'd0);

      // Reset during the Rm read
      cycle(1'b1, 32'hE1A01102, 32'h70, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      check("rstmid_valid", 32'(out_valid),      32'd0);
      check("rstmid_inst",  32'(out_inst_11_0),  32'd0);

      // Writeback bypass of r2 during the Rm read
      fwd_we = 1'b1; fwd_addr = 4'd2; fwd_data = 32'hAA;
      run_op(32'hE1A01102, 32'h80, 2);
`ifdef ARM_SHIFT_FWD_EN
      check("fwd_rm", out_rm_data, 32'hAA);
`else
      check("nofwd_rm", out_rm_data, 32'h11);
`endif
      fwd_we = 1'b0;
      drain();

      // Randomized traffic
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      for (int c = 0; c < 3000; c++) begin
         fwd_we   = ($urandom_range(0, 3) == 0);
         fwd_addr = 4'($urandom_range(0, 15));
         fwd_data = $urandom;
         cycle(($urandom_range(0, 9) < 7), rand_inst(), $urandom,
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0),
               ($urandom_range(0, 127) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
